// File: rtl/emmc_traffic_gen_pkg.sv
// Shared types and constants for the eMMC write/read-back traffic generator.
package emmc_tg_p;

  typedef enum logic [1:0] {
    MODE_INC   = 2'd0,
    MODE_LFSR  = 2'd1,
    MODE_CONST = 2'd2,
    MODE_WALK  = 2'd3
  } tg_mode_e;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_REQ  = 3'd1;
  localparam logic [2:0] S_WR_XFER = 3'd2;
  localparam logic [2:0] S_RD_REQ  = 3'd3;
  localparam logic [2:0] S_RD_XFER = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_FAULT   = 3'd6;

  // x^8+x^6+x^5+x^4+1 as Fibonacci taps on bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int FLT_TIMEOUT = 0;
  localparam int FLT_LENGTH  = 1;

endpackage

// File: rtl/emmc_traffic_gen_if.sv
// User-port bundle between the traffic generator (master) and emmc_sm (slave).
interface emmc_traffic_gen_if #(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 16
);
  logic              we;
  logic              start;
  logic [IDX_W-1:0]  blk_idx;
  logic [IDX_W-1:0]  blk_cnt;
  logic [DATA_W-1:0] wdat;
  logic [DATA_W-1:0] rdat;
  logic              dvalid;
  logic              ready;

  modport master (output we, start, blk_idx, blk_cnt, wdat, input rdat, dvalid, ready);
  modport slave  (input we, start, blk_idx, blk_cnt, wdat, output rdat, dvalid, ready);
endinterface

// File: rtl/emmc_traffic_gen_pattern_gen.sv
// Byte pattern source: incrementing, LFSR-8, constant or walking one.
module emmc_pattern_gen
  import emmc_tg_p::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              arst_ni,
  input  tg_mode_e          mode_i,
  input  logic [DATA_W-1:0] seed_i,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [DATA_W-1:0] byte_o
);
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(LFSR_TAPS);

  logic [DATA_W-1:0] cur_q, cur_d, seed_nz;

  always_comb begin
    // LFSR and walking one would lock up on an all-zero state
    seed_nz = (seed_i == '0) ? ONE : seed_i;
    cur_d   = cur_q;
    if (load_i) begin
      cur_d = (mode_i == MODE_LFSR || mode_i == MODE_WALK) ? seed_nz : seed_i;
    end else if (adv_i) begin
      case (mode_i)
        MODE_INC:  cur_d = cur_q + ONE;
        MODE_LFSR: cur_d = {cur_q[DATA_W-2:0], ^(cur_q & TAPS)};
        MODE_WALK: cur_d = {cur_q[DATA_W-2:0], cur_q[DATA_W-1]};
        default:   cur_d = cur_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) cur_q <= '0;
    else          cur_q <= cur_d;
  end

  assign byte_o = cur_q;

endmodule

// File: rtl/emmc_traffic_gen.sv
// Write/read-back traffic generator and checker for the emmc_sm user port.
// Optional EMMC_TG_ERR_INJECT_EN: err_inject_i flips bit0 of the next write byte.
module emmc_traffic_gen
  import emmc_tg_p::*;
#(
  parameter int DATA_W      = 8,
  parameter int IDX_W       = 16,
  parameter int BLK_BYTES   = 512,
  parameter int TIMEOUT_CYC = 2**20,
  parameter int ERR_CNT_W   = 16
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 run_i,
  input  logic                 loop_i,
  input  logic [1:0]           mode_i,
  input  logic [DATA_W-1:0]    seed_i,
  input  logic [IDX_W-1:0]     blk_idx_i,
  input  logic [IDX_W-1:0]     blk_cnt_i,
  emmc_traffic_gen_if.master   emmc,
  input  logic                 err_inject_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [31:0]          first_err_o,
  output logic [15:0]          pass_cnt_o,
  output logic [1:0]           fault_o
);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [2:0]           state_q, state_d;
  logic                 run_q, rdy_q;
  tg_mode_e             mode_q;
  logic [DATA_W-1:0]    seed_q;
  logic [IDX_W-1:0]     idx_q, cnt_q;
  logic [31:0]          byte_q, byte_d, ferr_q, ferr_d;
  logic                 ferr_vld_q, ferr_vld_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [15:0]          pass_q, pass_d;
  logic [1:0]           fault_q, fault_d;

  logic run_rise, rdy_rise, rdy_fall, in_req, in_xfer, act, timeout, len_bad;
  logic [31:0] exp_bytes;
  logic [DATA_W-1:0] pat, pg_seed;
  tg_mode_e pg_mode;
  logic pg_load, pg_adv;

  assign run_rise  = run_i & ~run_q;
  assign rdy_rise  = emmc.ready & ~rdy_q;
  assign rdy_fall  = ~emmc.ready & rdy_q;
  assign in_req    = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
  assign in_xfer   = (state_q == S_WR_XFER) || (state_q == S_RD_XFER);
  assign act       = emmc.dvalid | (emmc.ready ^ rdy_q);
  assign timeout   = (in_req | in_xfer) & ~act & (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign exp_bytes = 32'(cnt_q) * 32'(BLK_BYTES);
  // A strobe coinciding with the ready edge still belongs to this phase
  assign len_bad   = (byte_q + 32'(emmc.dvalid)) != exp_bytes;

  always_comb begin
    state_d    = state_q;
    byte_d     = byte_q;
    wd_d       = '0;
    err_d      = err_q;
    ferr_d     = ferr_q;
    ferr_vld_d = ferr_vld_q;
    pass_d     = pass_q;
    fault_d    = fault_q;
    if (in_req | in_xfer) wd_d = act ? '0 : wd_q + WD_W'(1);
    if (in_xfer && emmc.dvalid) byte_d = byte_q + 32'd1;
    if (in_req) byte_d = '0;
    case (state_q)
      S_IDLE: if (run_rise) begin
        state_d    = S_WR_REQ;
        err_d      = '0;
        ferr_d     = '0;
        ferr_vld_d = 1'b0;
        pass_d     = '0;
        fault_d    = '0;
      end
      S_WR_REQ: if (rdy_fall) state_d = S_WR_XFER;
      S_WR_XFER: if (rdy_rise) begin
        if (len_bad) fault_d[FLT_LENGTH] = 1'b1;
        state_d = S_RD_REQ;
      end
      S_RD_REQ: if (rdy_fall) state_d = S_RD_XFER;
      S_RD_XFER: begin
        if (emmc.dvalid && emmc.rdat != pat) begin
          if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
          if (!ferr_vld_q) begin
            ferr_d     = byte_q;
            ferr_vld_d = 1'b1;
          end
        end
        if (rdy_rise) begin
          if (len_bad) fault_d[FLT_LENGTH] = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        pass_d  = pass_q + 16'd1;
        state_d = (run_i && loop_i) ? S_WR_REQ : S_IDLE;
      end
      S_FAULT: if (!run_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (timeout) begin
      fault_d[FLT_TIMEOUT] = 1'b1;
      state_d              = S_FAULT;
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      rdy_q      <= 1'b0;
      mode_q     <= MODE_INC;
      seed_q     <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      byte_q     <= '0;
      ferr_q     <= '0;
      ferr_vld_q <= 1'b0;
      wd_q       <= '0;
      err_q      <= '0;
      pass_q     <= '0;
      fault_q    <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_i;
      rdy_q      <= emmc.ready;
      byte_q     <= byte_d;
      ferr_q     <= ferr_d;
      ferr_vld_q <= ferr_vld_d;
      wd_q       <= wd_d;
      err_q      <= err_d;
      pass_q     <= pass_d;
      fault_q    <= fault_d;
      if (state_q == S_IDLE && run_rise) begin
        mode_q <= tg_mode_e'(mode_i);
        seed_q <= seed_i;
        idx_q  <= blk_idx_i;
        cnt_q  <= (blk_cnt_i == '0) ? IDX_W'(1) : blk_cnt_i;
      end
    end
  end

  // In IDLE the generator is loaded straight from the inputs being latched
  assign pg_mode = (state_q == S_IDLE) ? tg_mode_e'(mode_i) : mode_q;
  assign pg_seed = (state_q == S_IDLE) ? seed_i : seed_q;
  assign pg_load = (state_d == S_WR_REQ || state_d == S_RD_REQ) && (state_d != state_q);
  assign pg_adv  = in_xfer & emmc.dvalid;

  emmc_pattern_gen #(.DATA_W(DATA_W)) u_pat (
    .clk_i  (clk_i),
    .arst_ni(arst_ni),
    .mode_i (pg_mode),
    .seed_i (pg_seed),
    .load_i (pg_load),
    .adv_i  (pg_adv),
    .byte_o (pat)
  );

`ifdef EMMC_TG_ERR_INJECT_EN
  logic inj_q;
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni)                                    inj_q <= 1'b0;
    else if (err_inject_i)                           inj_q <= 1'b1;
    else if (state_q == S_WR_XFER && emmc.dvalid)    inj_q <= 1'b0;
  end
  assign emmc.wdat = pat ^ {{(DATA_W-1){1'b0}}, inj_q & (state_q == S_WR_XFER)};
`else
  logic unused_inj;
  assign unused_inj = err_inject_i;
  assign emmc.wdat  = pat;
`endif

  assign emmc.we      = (state_q == S_WR_REQ) || (state_q == S_WR_XFER);
  assign emmc.start   = in_req & emmc.ready;
  assign emmc.blk_idx = idx_q;
  assign emmc.blk_cnt = cnt_q;
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_FAULT);
  assign done_o       = (state_q == S_DONE);
  assign err_cnt_o    = err_q;
  assign first_err_o  = ferr_q;
  assign pass_cnt_o   = pass_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_emmc_traffic_gen.sv
// Directed bench: behavioural emmc_sm with loopback RAM driving emmc_traffic_gen.
`timescale 1ns/1ps
module tb_emmc_traffic_gen;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic run = 1'b0, loop_en = 1'b0, err_inj = 1'b0;
  logic [1:0] mode = '0;
  logic [7:0] seed = '0;
  logic [15:0] bidx = '0, bcnt = '0;
  logic busy, done;
  logic [15:0] err_cnt, pass_cnt;
  logic [31:0] first_err;
  logic [1:0] fault;

  emmc_traffic_gen_if #(.DATA_W(8), .IDX_W(16)) bus ();

  emmc_traffic_gen #(.DATA_W(8), .IDX_W(16), .BLK_BYTES(512), .TIMEOUT_CYC(1000), .ERR_CNT_W(16)) dut (
    .clk_i(clk), .arst_ni(rst_n), .run_i(run), .loop_i(loop_en), .mode_i(mode), .seed_i(seed),
    .blk_idx_i(bidx), .blk_cnt_i(bcnt), .emmc(bus), .err_inject_i(err_inj), .busy_o(busy),
    .done_o(done), .err_cnt_o(err_cnt), .first_err_o(first_err), .pass_cnt_o(pass_cnt), .fault_o(fault)
  );

  int n_tests = 0, n_fail = 0;
  int done_seen = 0;
  int stop_after = -1, corrupt_at = -1, short_by = 0;
  logic [7:0] mem [int];

  function automatic logic [7:0] mrd(input int a);
    return mem.exists(a) ? mem[a] : 8'hEE;
  endfunction

  initial forever begin
    @(posedge clk); #1;
    if (done) done_seen++;
  end

  // emmc_sm model: ready idles high, drops on start, streams bytes, rises at end
  initial begin
    int base, total, k;
    logic w;
    bus.ready = 1'b1; bus.dvalid = 1'b0; bus.rdat = '0;
    forever begin
      @(posedge clk); #1;
      if (rst_n && bus.start) begin
        w = bus.we; base = int'(bus.blk_idx) * 512;
        total = int'(bus.blk_cnt) * 512 - short_by;
        bus.ready = 1'b0;
        k = 0;
        while (k < total && !(stop_after >= 0 && k >= stop_after)) begin
          @(posedge clk); #1;
          bus.dvalid = 1'b1;
          if (w) mem[base+k] = bus.wdat;
          else   bus.rdat = mrd(base+k) ^ ((k == corrupt_at) ? 8'h40 : 8'h00);
          k++;
        end
        @(posedge clk); #1; bus.dvalid = 1'b0;
        if (stop_after >= 0 && k >= stop_after) while (busy) begin @(posedge clk); #1; end
        @(posedge clk); #1; bus.ready = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pass(input logic [1:0] m, input logic [7:0] s, input logic [15:0] i, c, input logic lp);
    mode = m; seed = s; bidx = i; bcnt = c; loop_en = lp; run = 1'b1;
    tick(1);
  endtask

  task automatic wait_done(input int target, input int max_cyc, input string tag);
    int c = 0;
    while (done_seen < target && c < max_cyc) begin tick(1); c++; end
    n_tests++;
    if (done_seen < target) begin n_fail++; $display("FAIL %s_done: pulses=%0d required=%0d", tag, done_seen, target); end
  endtask

  task automatic test_reset();
    tick(3);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got=%b exp=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got=%b exp=0", done); end
    n_tests++; if ({err_cnt, pass_cnt, fault} !== 34'd0) begin n_fail++; $display("FAIL rst_cnts: got=%h exp=0", {err_cnt, pass_cnt, fault}); end
    n_tests++; if (first_err !== 32'd0) begin n_fail++; $display("FAIL rst_first_err: got=%0d exp=0", first_err); end
    n_tests++; if ({bus.we, bus.start, bus.wdat} !== 10'd0) begin n_fail++; $display("FAIL rst_bus: got=%h exp=0", {bus.we, bus.start, bus.wdat}); end
    rst_n = 1'b1;
    tick(2);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got=%b exp=0", busy); end
  endtask

  task automatic test_incr();
    int d0 = done_seen;
    int b = 5 * 512;
    start_pass(2'd0, 8'h00, 16'd5, 16'd2, 1'b0);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL incr_busy: got=%b exp=1", busy); end
    wait_done(d0 + 1, 5000, "incr");
    n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL incr_err: got=%0d exp=0", err_cnt); end
    n_tests++; if (pass_cnt !== 16'd1) begin n_fail++; $display("FAIL incr_pass: got=%0d exp=1", pass_cnt); end
    n_tests++; if (fault !== 2'b00) begin n_fail++; $display("FAIL incr_fault: got=%b exp=00", fault); end
    n_tests++; if ({bus.blk_idx, bus.blk_cnt} !== {16'd5, 16'd2}) begin n_fail++; $display("FAIL incr_cfg: got=%h exp=00050002", {bus.blk_idx, bus.blk_cnt}); end
    n_tests++; if ({mrd(b), mrd(b+255), mrd(b+256), mrd(b+1023)} !== 32'h00FF00FF) begin
      n_fail++; $display("FAIL incr_data: got=%h exp=00ff00ff", {mrd(b), mrd(b+255), mrd(b+256), mrd(b+1023)}); end
    n_tests++; if (mem.exists(b+1024) || mem.exists(b-1)) begin n_fail++; $display("FAIL incr_range: bytes written outside blocks 5..6"); end
    run = 1'b0; tick(3);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL incr_idle: got=%b exp=0", busy); end
  endtask

  task automatic test_lfsr();
    logic [7:0] exp [6] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};
    int d0 = done_seen;
    start_pass(2'd1, 8'h00, 16'd20, 16'd1, 1'b0);
    wait_done(d0 + 1, 3000, "lfsr");
    for (int i = 0; i < 6; i++) begin
      n_tests++; if (mrd(20*512+i) !== exp[i]) begin n_fail++; $display("FAIL lfsr_byte%0d: got=%h exp=%h", i, mrd(20*512+i), exp[i]); end
    end
    n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL lfsr_err: got=%0d exp=0", err_cnt); end
    run = 1'b0; tick(3);
  endtask

  task automatic test_patterns();
    int d0 = done_seen;
    start_pass(2'd3, 8'h81, 16'd30, 16'd0, 1'b0);
    wait_done(d0 + 1, 3000, "walk");
    n_tests++; if ({mrd(15360), mrd(15361), mrd(15362), mrd(15871)} !== 32'h810306C0) begin
      n_fail++; $display("FAIL walk_data: got=%h exp=810306c0", {mrd(15360), mrd(15361), mrd(15362), mrd(15871)}); end
    n_tests++; if (bus.blk_cnt !== 16'd1 || mem.exists(15872)) begin n_fail++; $display("FAIL cnt0_as_1: blk_cnt_o=%0d exp=1", bus.blk_cnt); end
    n_tests++; if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL walk_err: got=%0d exp=0", err_cnt); end
    run = 1'b0; tick(3);
    start_pass(2'd2, 8'hA5, 16'd31, 16'd1, 1'b0);
    wait_done(d0 + 2, 3000, "const");
    n_tests++; if ({mrd(15872), mrd(15872+300), mrd(15872+511)} !== 24'hA5A5A5) begin
      n_fail++; $display("FAIL const_data: got=%h exp=a5a5a5", {mrd(15872), mrd(15872+300), mrd(15872+511)}); end
    run = 1'b0; tick(3);
  endtask

  task automatic test_corrupt();
    int d0 = done_seen;
    corrupt_at = 300;
    start_pass(2'd0, 8'h10, 16'd40, 16'd1, 1'b0);
    wait_done(d0 + 1, 3000, "corrupt");
    n_tests++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL corrupt_err: got=%0d exp=1", err_cnt); end
    n_tests++; if (first_err !== 32'd300) begin n_fail++; $display("FAIL corrupt_first: got=%0d exp=300", first_err); end
    n_tests++; if (fault !== 2'b00) begin n_fail++; $display("FAIL corrupt_fault: got=%b exp=00", fault); end
    corrupt_at = -1; run = 1'b0; tick(3);
  endtask

  task automatic test_length();
    int d0 = done_seen;
    short_by = 1;
    start_pass(2'd0, 8'h00, 16'd50, 16'd1, 1'b0);
    wait_done(d0 + 1, 3000, "length");
    n_tests++; if (fault !== 2'b10) begin n_fail++; $display("FAIL length_fault: got=%b exp=10", fault); end
    n_tests++; if ({err_cnt, pass_cnt} !== {16'd0, 16'd1}) begin n_fail++; $display("FAIL length_cnts: got=%h exp=00000001", {err_cnt, pass_cnt}); end
    short_by = 0; run = 1'b0; tick(3);
  endtask

  task automatic test_timeout();
    int c = 0;
    int d0 = done_seen;
    stop_after = 100;
    start_pass(2'd0, 8'h00, 16'd60, 16'd1, 1'b0);
    while (busy && c < 3000) begin tick(1); c++; end
    n_tests++; if (c < 1000 || c >= 1200) begin n_fail++; $display("FAIL tmo_latency: got=%0d cycles exp=1000..1199", c); end
    n_tests++; if (fault !== 2'b01) begin n_fail++; $display("FAIL tmo_fault: got=%b exp=01", fault); end
    n_tests++; if (bus.start !== 1'b0) begin n_fail++; $display("FAIL tmo_start: got=%b exp=0", bus.start); end
    stop_after = -1;
    tick(5);
    n_tests++; if (busy !== 1'b0 || pass_cnt !== 16'd0 || done_seen != d0) begin
      n_fail++; $display("FAIL tmo_hold: busy=%b pass=%0d dones=%0d exp 0,0,%0d", busy, pass_cnt, done_seen, d0); end
    run = 1'b0; tick(3);
    run = 1'b1; tick(3);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tmo_restart: got=%b exp=1", busy); end
    wait_done(d0 + 1, 3000, "tmo_restart");
    n_tests++; if (fault !== 2'b00) begin n_fail++; $display("FAIL tmo_clear: got=%b exp=00", fault); end
    run = 1'b0; tick(3);
  endtask

  task automatic test_loop();
    int d0 = done_seen;
    start_pass(2'd0, 8'h00, 16'd70, 16'd1, 1'b1);
    wait_done(d0 + 3, 8000, "loop3");
    tick(100);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL loop_4th_busy: got=%b exp=1", busy); end
    run = 1'b0;
    wait_done(d0 + 4, 3000, "loop4");
    tick(1);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL loop_busy_fall: got=%b exp=0", busy); end
    tick(1500);
    n_tests++; if (pass_cnt !== 16'd4 || done_seen != d0 + 4) begin
      n_fail++; $display("FAIL loop_pass: got=%0d dones=%0d exp=4 dones=%0d", pass_cnt, done_seen, d0 + 4); end
    loop_en = 1'b0;
  endtask

  task automatic test_inject();
    int d0 = done_seen;
`ifdef EMMC_TG_ERR_INJECT_EN
    logic [15:0] exp_err = 16'd1;
    logic [7:0]  exp_b0  = 8'h01;
`else
    logic [15:0] exp_err = 16'd0;
    logic [7:0]  exp_b0  = 8'h00;
`endif
    err_inj = 1'b1; tick(1); err_inj = 1'b0; tick(2);
    start_pass(2'd0, 8'h00, 16'd80, 16'd1, 1'b0);
    wait_done(d0 + 1, 3000, "inject");
    n_tests++; if (err_cnt !== exp_err) begin n_fail++; $display("FAIL inject_err: got=%0d exp=%0d", err_cnt, exp_err); end
    n_tests++; if (first_err !== 32'd0) begin n_fail++; $display("FAIL inject_first: got=%0d exp=0", first_err); end
    n_tests++; if ({mrd(80*512), mrd(80*512+1)} !== {exp_b0, 8'h01}) begin
      n_fail++; $display("FAIL inject_wdata: got=%h exp=%h01", {mrd(80*512), mrd(80*512+1)}, exp_b0); end
    run = 1'b0; tick(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "bench time limit");
  end

  initial begin
    test_reset();
    test_incr();
    test_lfsr();
    test_patterns();
    test_corrupt();
    test_length();
    test_timeout();
    test_loop();
    test_inject();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
